// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin arbiter and sequencer sharing one WIDTHxWIDTH multiplier
// among N_REQ requesters. Latches the winner's operands, drives the multiplier's
// op_start/op_clear handshake, returns the product with a one-cycle done pulse and
// aborts stalled operations with a watchdog.
//
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   req[N_REQ]                   per-requester request, held until done/err
//   req_a, req_b                 per-requester operands, slice i for requester i
//   gnt[N_REQ]                   one-hot grant, high while requester owns the multiplier
//   done[N_REQ], err[N_REQ]      one-cycle completion / watchdog-abort pulses
//   result[2*WIDTH]              last captured product, held until next capture
//   busy                         high whenever not idle
//   m_multiplier, m_multiplicand latched operands to the multiplier
//   m_op_start, m_op_clear       multiplier control
//   m_op_done, m_result          multiplier completion and product
module mul_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic [N_REQ-1:0]       err,
  output logic [2*WIDTH-1:0]     result,
  output logic                   busy,
  output logic [WIDTH-1:0]       m_multiplier,
  output logic [WIDTH-1:0]       m_multiplicand,
  output logic                   m_op_start,
  output logic                   m_op_clear,
  input  logic                   m_op_done,
  input  logic [2*WIDTH-1:0]     m_result
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned WdW  = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StClear} state_e;

  state_e               state_q;
  logic [N_REQ-1:0]     gnt_q;
  logic [N_REQ-1:0]     done_q;
  logic [N_REQ-1:0]     err_q;
  logic [2*WIDTH-1:0]   result_q;
  logic                 busy_q;
  logic [WIDTH-1:0]     mult_q;
  logic [WIDTH-1:0]     mcand_q;
  logic                 start_q;
  logic                 clear_q;
  logic [WdW-1:0]       wd_q;
  logic [IdxW-1:0]      last_q;

  // Winner selection: first set req bit searching upward from last_q+1, wrapping.
  logic                 any_req;
  logic [IdxW-1:0]      cand;
  logic [IdxW-1:0]      win_idx;
  logic [N_REQ-1:0]     win_onehot;
  logic [WIDTH-1:0]     win_a;
  logic [WIDTH-1:0]     win_b;

  always_comb begin
    any_req = 1'b0;
    cand    = '0;
    win_idx = last_q;
    // Walk the distances from farthest to nearest so the nearest set bit wins.
    for (int i = int'(N_REQ); i >= 1; i--) begin
      cand = IdxW'((int'(last_q) + i) % int'(N_REQ));
      if (req[cand]) begin
        any_req = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    win_onehot = '0;
    win_a      = '0;
    win_b      = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (win_idx == IdxW'(i)) begin
        win_onehot[i] = 1'b1;
        win_a         = req_a[i*WIDTH +: WIDTH];
        win_b         = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      mult_q   <= '0;
      mcand_q  <= '0;
      start_q  <= 1'b0;
      clear_q  <= 1'b0;
      wd_q     <= '0;
      last_q   <= IdxW'(N_REQ - 1);
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            mult_q  <= win_a;
            mcand_q <= win_b;
            gnt_q   <= win_onehot;
            start_q <= 1'b1;
            wd_q    <= '0;
            last_q  <= win_idx;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          wd_q <= wd_q + WdW'(1);
          // Completion beats withdrawal, which beats the watchdog.
          if (m_op_done) begin
            result_q <= m_result;
            done_q   <= gnt_q;
            start_q  <= 1'b0;
            clear_q  <= 1'b1;
            state_q  <= StClear;
          end else if (!req[last_q]) begin
            start_q <= 1'b0;
            clear_q <= 1'b1;
            state_q <= StClear;
          end else if (wd_q == WdW'(TIMEOUT - 1)) begin
            err_q   <= gnt_q;
            start_q <= 1'b0;
            clear_q <= 1'b1;
            state_q <= StClear;
          end
        end
        StClear: begin
          clear_q <= 1'b0;
          done_q  <= '0;
          err_q   <= '0;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gnt            = gnt_q;
  assign done           = done_q;
  assign err            = err_q;
  assign result         = result_q;
  assign busy           = busy_q;
  assign m_multiplier   = mult_q;
  assign m_multiplicand = mcand_q;
  assign m_op_start     = start_q;
  assign m_op_clear     = clear_q;

endmodule
